vga_mode_ctrl: RTL and testbench
================================

# vga_mode_ctrl

Mode-switch controller for the 640x480 VGA timing generator. It owns the six porch/sync configuration buses that feed the generator and accepts mode-change requests over a valid/ready handshake. It applies new timing only at a vertical-sync boundary and mutes video while the monitor re-locks. It sits between the game/control logic and the timing generator, in the `pixel_clk` domain.

## Interface
Parameters:
- `MUTE_FRAMES`, default 2: frame boundaries to keep video muted after a new mode is applied (1..15).
- `SYNC_STAGES`, default 2: synchronizer depth on `vga_vs` (2..3).
- `TIMEOUT_CYCLES`, default 1048576: `pixel_clk` cycles to wait for a frame boundary before forcing the apply.

Ports:
- `pixel_clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mode_req_valid`  in  1  request strobe; held until accepted.
- `mode_req_sel`  in  2  requested mode index 0..3.
- `mode_req_ready`  out  1  high only in IDLE.
- `vga_vs`  in  1  vsync from the generator; active low, idle high.
- `h_fporch`, `h_sync`, `h_bporch`  out  12 each  horizontal configuration to the generator.
- `v_fporch`, `v_sync`, `v_bporch`  out  12 each  vertical configuration to the generator.
- `mode_cur`  out  2  currently applied mode.
- `video_mute`  out  1  downstream must blank RGB while high.
- `mode_done`  out  1  one-cycle pulse when a requested switch completes.

## Operation
- Mode table, with h fp/sync/bp and v fp/sync/bp:
  - mode 0 (60 Hz): 16/96/48, 10/2/33
  - mode 1 (72 Hz): 24/40/128, 9/3/28
  - mode 2 (75 Hz): 16/64/120, 1/3/16
  - mode 3 (85 Hz): 56/56/80, 1/3/25
- `vga_vs` passes through a `SYNC_STAGES` flop chain, reset to 1. `frame_tick` is a single-cycle pulse on the synchronized falling edge.
- The FSM has three states: IDLE, WAIT_FRAME and SETTLE.
- IDLE:
  - Accept a request when `valid && ready`; latch `mode_req_sel` as `pending`.
  - If `pending == mode_cur`, stay in IDLE with no mute. `mode_done` pulses the next cycle.
  - Otherwise go to WAIT_FRAME, assert `video_mute`, and clear the timeout counter.
- WAIT_FRAME:
  - On `frame_tick`, or when the timeout counter reaches `TIMEOUT_CYCLES-1`, load the six config outputs and `mode_cur` from `pending`.
  - Clear the frame counter and go to SETTLE.
- SETTLE:
  - Count `frame_tick`s.
  - On the `MUTE_FRAMES`-th tick, deassert `video_mute` and go to IDLE.
  - `mode_done` pulses only if SETTLE was entered from WAIT_FRAME.
- `frame_tick` and an accepted request in the same IDLE cycle: the tick is ignored, and the switch waits for the next tick.
- While not in IDLE, `ready` is low; requests are stalled, not dropped.

## Timing
- Reset values:
  - Config outputs hold mode 0 values; `mode_cur` = 0.
  - `video_mute` = 1, `mode_done` = 0, `mode_req_ready` = 0.
  - FSM is in SETTLE, with its post-reset flag set.
- After reset, video unmutes and `ready` rises the cycle after the `MUTE_FRAMES`-th `frame_tick`. No `mode_done` pulse is produced.
- Latencies for a request accepted at the edge ending cycle T:
  - `video_mute` and the WAIT_FRAME state are visible in cycle T+1.
  - New config values are visible one cycle after the `frame_tick` cycle.
  - `frame_tick` occurs `SYNC_STAGES`+1 cycles after `vga_vs` falls.
- All outputs are registered; there are no combinational input-to-output paths except `mode_req_ready` = (state == IDLE), which is decoded from registered state.
- Config outputs change in exactly one cycle per switch; all six change atomically.
- Counter widths:
  - Timeout counter: 21 bits, saturating; it is not used outside WAIT_FRAME.
  - Frame counter: 4 bits.
- Reset asserted mid-switch returns immediately to reset values. `pending` is discarded.

## Structure
- Package `vga_pkg`: the four-entry mode table as a constant array of a typedef struct (six 12-bit fields), `H_ACTIVE` = 640, `V_ACTIVE` = 480, and the FSM state enum.
- Sub-module `vga_vs_sync`: the parameterized synchronizer plus falling-edge detector producing `frame_tick`.
- FSM, counters and output registers live in `vga_mode_ctrl`.

## Test plan
- **Reset:** drop `rst_n`, then toggle `vga_vs` low every 1000 cycles.
  - Outputs hold 16/96/48/10/2/33 and `mute` = 1.
  - `ready` rises one cycle after the 2nd tick.
  - No `mode_done` pulse.
- **Switch to mode 3:** request `sel` = 3 in IDLE.
  - `mute` = 1 next cycle.
  - Config becomes 56/56/80/1/3/25 exactly one cycle after the next tick.
  - `mute` = 0 and a single `mode_done` pulse one cycle after the 2nd following tick.
- **Same-mode request:** request `sel` = `mode_cur`.
  - `mute` stays 0 and config is unchanged.
  - `mode_done` pulses next cycle; `ready` never drops.
- **Stalled request:** raise `valid` with `sel` = 1 while in SETTLE.
  - `ready` stays 0 and the request is not accepted.
  - Accepted on the first IDLE cycle; mode 1 is applied at the following tick.
- **Stuck vsync:** hold `vga_vs` high after a request for mode 2.
  - Config becomes 16/64/120/1/3/16 after exactly `TIMEOUT_CYCLES` cycles in WAIT_FRAME.
  - `mute` persists until 2 ticks are seen.
- **Reset mid-switch:** assert `rst_n` low while in WAIT_FRAME for mode 1.
  - Outputs revert immediately to mode 0 and `mute` = 1.
  - Mode 1 is never applied.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA mode-switch controller: mode timing table,
// active-area constants and the controller FSM state encoding.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef struct packed {
    logic [11:0] h_fporch;
    logic [11:0] h_sync;
    logic [11:0] h_bporch;
    logic [11:0] v_fporch;
    logic [11:0] v_sync;
    logic [11:0] v_bporch;
  } mode_cfg_t;

  // Index = mode number: 60, 72, 75 and 85 Hz variants of 640x480.
  localparam mode_cfg_t MODE_TABLE [4] = '{
    '{12'd16, 12'd96, 12'd48,  12'd10, 12'd2, 12'd33},
    '{12'd24, 12'd40, 12'd128, 12'd9,  12'd3, 12'd28},
    '{12'd16, 12'd64, 12'd120, 12'd1,  12'd3, 12'd16},
    '{12'd56, 12'd56, 12'd80,  12'd1,  12'd3, 12'd25}
  };

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_SETTLE     = 2'd2
  } state_t;

endpackage

// File: rtl/vga_vs_sync.sv
// Synchronizes the generator's active-low vsync and emits a registered
// one-cycle frame_tick on its falling edge.
module vga_vs_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vs,
  output logic frame_tick
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  // Chain resets to the idle-high level so reset release never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '1;
      last_q     <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], vs};
      last_q     <= sync_q[SYNC_STAGES-1];
      frame_tick <= last_q & ~sync_q[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/vga_mode_ctrl.sv
// Mode-switch controller: accepts mode requests, applies new porch/sync
// timing at a frame boundary and mutes video while the monitor re-locks.
module vga_mode_ctrl
  import vga_pkg::*;
#(
  parameter int MUTE_FRAMES    = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic        mode_req_valid,
  input  logic [1:0]  mode_req_sel,
  output logic        mode_req_ready,
  input  logic        vga_vs,
  output logic [11:0] h_fporch,
  output logic [11:0] h_sync,
  output logic [11:0] h_bporch,
  output logic [11:0] v_fporch,
  output logic [11:0] v_sync,
  output logic [11:0] v_bporch,
  output logic [1:0]  mode_cur,
  output logic        video_mute,
  output logic        mode_done
);

  localparam int TW = 21;
  localparam int FW = 4;

  state_t          state;
  state_t          state_next;
  logic            frame_tick;
  logic [1:0]      pending;
  logic [TW-1:0]   tcnt;
  logic [FW-1:0]   fcnt;
  logic            from_wait;
  mode_cfg_t       cfg_q;
  logic            accept;
  logic            same_mode;
  logic            apply;
  logic            finish;

  vga_vs_sync #(.SYNC_STAGES(SYNC_STAGES)) u_vs_sync (
    .clk        (pixel_clk),
    .rst_n      (rst_n),
    .vs         (vga_vs),
    .frame_tick (frame_tick)
  );

  // Handshake: a request transfers on any edge where mode_req_valid and
  // mode_req_ready are both high; the requester holds valid/sel until then.
  assign mode_req_ready = (state == ST_IDLE);

  assign h_fporch = cfg_q.h_fporch;
  assign h_sync   = cfg_q.h_sync;
  assign h_bporch = cfg_q.h_bporch;
  assign v_fporch = cfg_q.v_fporch;
  assign v_sync   = cfg_q.v_sync;
  assign v_bporch = cfg_q.v_bporch;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) state <= ST_SETTLE;
    else        state <= state_next;
  end

  // A frame_tick landing in IDLE is deliberately ignored, even alongside an accept.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    same_mode  = 1'b0;
    apply      = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mode_req_valid) begin
          accept = 1'b1;
          if (mode_req_sel == mode_cur) same_mode = 1'b1;
          else                          state_next = ST_WAIT_FRAME;
        end
      end
      ST_WAIT_FRAME: begin
        if (frame_tick || tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          apply      = 1'b1;
          state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (frame_tick && fcnt == FW'(MUTE_FRAMES - 1)) begin
          finish     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // from_wait distinguishes a real switch from the post-reset settle.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= 2'd0;
      tcnt       <= '0;
      fcnt       <= '0;
      from_wait  <= 1'b0;
      cfg_q      <= MODE_TABLE[0];
      mode_cur   <= 2'd0;
      video_mute <= 1'b1;
      mode_done  <= 1'b0;
    end else begin
      mode_done <= 1'b0;
      if (accept) begin
        pending <= mode_req_sel;
        if (same_mode) begin
          mode_done <= 1'b1;
        end else begin
          video_mute <= 1'b1;
          tcnt       <= '0;
        end
      end
      if (state == ST_WAIT_FRAME && !apply && tcnt != '1) tcnt <= tcnt + 1'b1;
      if (apply) begin
        cfg_q     <= MODE_TABLE[pending];
        mode_cur  <= pending;
        fcnt      <= '0;
        from_wait <= 1'b1;
      end
      if (state == ST_SETTLE && frame_tick) begin
        if (finish) begin
          video_mute <= 1'b0;
          mode_done  <= from_wait;
          from_wait  <= 1'b0;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Self-checking bench for vga_mode_ctrl: mode table vectors, frame-boundary
// corner sequences and randomized switches against a transaction-level model.
module tb_vga_mode_ctrl;

  localparam int SYNC = 2;
  localparam int MUTE = 2;
  localparam int TMO  = 300;

  logic        clk;
  logic        rst_n;
  logic        mode_req_valid;
  logic [1:0]  mode_req_sel;
  logic        mode_req_ready;
  logic        vga_vs;
  logic [11:0] h_fporch, h_sync, h_bporch, v_fporch, v_sync, v_bporch;
  logic [1:0]  mode_cur;
  logic        video_mute;
  logic        mode_done;

  vga_mode_ctrl #(
    .MUTE_FRAMES    (MUTE),
    .SYNC_STAGES    (SYNC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .pixel_clk      (clk),
    .rst_n          (rst_n),
    .mode_req_valid (mode_req_valid),
    .mode_req_sel   (mode_req_sel),
    .mode_req_ready (mode_req_ready),
    .vga_vs         (vga_vs),
    .h_fporch       (h_fporch),
    .h_sync         (h_sync),
    .h_bporch       (h_bporch),
    .v_fporch       (v_fporch),
    .v_sync         (v_sync),
    .v_bporch       (v_bporch),
    .mode_cur       (mode_cur),
    .video_mute     (video_mute),
    .mode_done      (mode_done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int         n_vec = 0;
  int         n_err = 0;
  int         done_cnt = 0;
  logic [1:0] model_mode;
  wire [71:0] dut_cfg = {h_fporch, h_sync, h_bporch, v_fporch, v_sync, v_bporch};

  always @(negedge clk) if (rst_n && mode_done) done_cnt++;

  typedef struct {
    logic [1:0]  sel;
    logic [71:0] cfg;
  } vec_t;
  vec_t vecs[6];

  function automatic logic [71:0] ref_cfg(input logic [1:0] m);
    case (m)
      2'd0:    ref_cfg = {12'd16, 12'd96, 12'd48,  12'd10, 12'd2, 12'd33};
      2'd1:    ref_cfg = {12'd24, 12'd40, 12'd128, 12'd9,  12'd3, 12'd28};
      2'd2:    ref_cfg = {12'd16, 12'd64, 12'd120, 12'd1,  12'd3, 12'd16};
      default: ref_cfg = {12'd56, 12'd56, 12'd80,  12'd1,  12'd3, 12'd25};
    endcase
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drops vsync and returns in the cycle where frame_tick is high.
  task automatic vs_to_tick();
    vga_vs = 1'b0;
    repeat (SYNC + 1) step();
  endtask

  task automatic vs_release();
    vga_vs = 1'b1;
    repeat (SYNC + 2) step();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!mode_req_ready && n < 100) begin
      step();
      n++;
    end
    check("ready_wait", 72'(mode_req_ready), 72'(1));
  endtask

  task automatic req_accept(input logic [1:0] sel);
    wait_ready();
    mode_req_valid = 1'b1;
    mode_req_sel   = sel;
    step();
    mode_req_valid = 1'b0;
  endtask

  // Starts in WAIT_FRAME with vsync high; ends after the apply tick, vsync high.
  task automatic apply_phase(input logic [71:0] old, input logic [71:0] exp,
                             input logic [1:0] sel, input int wait_cyc);
    check("wait_mute", 72'(video_mute), 72'(1));
    check("wait_ready_low", 72'(mode_req_ready), 72'(0));
    check("wait_cfg_old", dut_cfg, old);
    repeat (wait_cyc) step();
    vs_to_tick();
    check("tick_cfg_old", dut_cfg, old);
    step();
    check("apply_cfg", dut_cfg, exp);
    check("apply_mode_cur", 72'(mode_cur), 72'(sel));
    check("apply_mute", 72'(video_mute), 72'(1));
    vs_release();
  endtask

  // Counts MUTE ticks; returns in the first IDLE cycle with vsync still low.
  task automatic settle(input logic exp_done);
    for (int f = 1; f <= MUTE; f++) begin
      vs_to_tick();
      check("settle_tick_mute", 72'(video_mute), 72'(1));
      check("settle_tick_ready", 72'(mode_req_ready), 72'(0));
      step();
      if (f < MUTE) begin
        check("settle_mid_mute", 72'(video_mute), 72'(1));
        vs_release();
      end else begin
        check("settle_end_mute", 72'(video_mute), 72'(0));
        check("settle_end_ready", 72'(mode_req_ready), 72'(1));
        check("settle_end_done", 72'(mode_done), 72'(exp_done));
      end
    end
  endtask

  task automatic do_switch(input logic [1:0] sel, input logic [71:0] exp, input int wait_cyc);
    logic [71:0] old;
    int d0;
    old = ref_cfg(model_mode);
    d0  = done_cnt;
    req_accept(sel);
    if (sel == model_mode) begin
      check("same_done", 72'(mode_done), 72'(1));
      check("same_mute", 72'(video_mute), 72'(0));
      check("same_ready", 72'(mode_req_ready), 72'(1));
      check("same_cfg", dut_cfg, exp);
      step();
      check("same_done_off", 72'(mode_done), 72'(0));
    end else begin
      apply_phase(old, exp, sel, wait_cyc);
      settle(1'b1);
      vs_release();
    end
    check("done_count", 72'(done_cnt - d0), 72'(1));
    model_mode = sel;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [1:0]  sel;
    logic [71:0] old;
    int d0;

    rst_n = 1'b0; vga_vs = 1'b1; mode_req_valid = 1'b0; mode_req_sel = 2'd0;
    vecs[0] = '{2'd3, {12'd56, 12'd56, 12'd80,  12'd1,  12'd3, 12'd25}};
    vecs[1] = '{2'd3, {12'd56, 12'd56, 12'd80,  12'd1,  12'd3, 12'd25}};
    vecs[2] = '{2'd1, {12'd24, 12'd40, 12'd128, 12'd9,  12'd3, 12'd28}};
    vecs[3] = '{2'd2, {12'd16, 12'd64, 12'd120, 12'd1,  12'd3, 12'd16}};
    vecs[4] = '{2'd0, {12'd16, 12'd96, 12'd48,  12'd10, 12'd2, 12'd33}};
    vecs[5] = '{2'd0, {12'd16, 12'd96, 12'd48,  12'd10, 12'd2, 12'd33}};

    // Reset and post-reset settle
    repeat (3) step();
    check("rst_cfg", dut_cfg, ref_cfg(2'd0));
    check("rst_mute", 72'(video_mute), 72'(1));
    check("rst_ready", 72'(mode_req_ready), 72'(0));
    check("rst_done", 72'(mode_done), 72'(0));
    check("rst_mode_cur", 72'(mode_cur), 72'(0));
    rst_n = 1'b1;
    step();
    settle(1'b0);
    vs_release();
    check("rst_no_done", 72'(done_cnt), 72'(0));
    model_mode = 2'd0;

    // Table-driven mode switches, including same-mode requests
    for (int i = 0; i < 6; i++) do_switch(vecs[i].sel, vecs[i].cfg, i * 3);

    // Tick coinciding with an accepted request is ignored
    wait_ready();
    vga_vs = 1'b0;
    repeat (SYNC + 1) step();
    old = ref_cfg(model_mode);
    mode_req_valid = 1'b1; mode_req_sel = 2'd1;
    step();
    mode_req_valid = 1'b0;
    vs_release();
    apply_phase(old, ref_cfg(2'd1), 2'd1, 3);
    settle(1'b1);
    vs_release();
    model_mode = 2'd1;

    // Request stalled while in SETTLE, accepted on the first IDLE cycle
    req_accept(2'd3);
    apply_phase(ref_cfg(2'd1), ref_cfg(2'd3), 2'd3, 2);
    mode_req_valid = 1'b1; mode_req_sel = 2'd1;
    settle(1'b1);
    step();
    mode_req_valid = 1'b0;
    check("stall_accepted", 72'(mode_req_ready), 72'(0));
    vs_release();
    apply_phase(ref_cfg(2'd3), ref_cfg(2'd1), 2'd1, 0);
    settle(1'b1);
    vs_release();
    model_mode = 2'd1;

    // Stuck vsync: timeout forces the apply
    d0 = done_cnt;
    req_accept(2'd2);
    check("stuck_mute", 72'(video_mute), 72'(1));
    repeat (TMO - 1) step();
    check("stuck_cfg_old", dut_cfg, ref_cfg(2'd1));
    step();
    check("stuck_cfg_new", dut_cfg, ref_cfg(2'd2));
    check("stuck_mode_cur", 72'(mode_cur), 72'(2));
    check("stuck_mute_hold", 72'(video_mute), 72'(1));
    settle(1'b1);
    vs_release();
    check("stuck_done_count", 72'(done_cnt - d0), 72'(1));
    model_mode = 2'd2;

    // Reset asserted while waiting to apply mode 1
    req_accept(2'd1);
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    check("midrst_cfg", dut_cfg, ref_cfg(2'd0));
    check("midrst_mute", 72'(video_mute), 72'(1));
    check("midrst_mode_cur", 72'(mode_cur), 72'(0));
    check("midrst_ready", 72'(mode_req_ready), 72'(0));
    step();
    rst_n = 1'b1;
    step();
    settle(1'b0);
    vs_release();
    vs_to_tick();
    step();
    check("midrst_never_applied", dut_cfg, ref_cfg(2'd0));
    check("midrst_mode_cur_final", 72'(mode_cur), 72'(0));
    vs_release();
    model_mode = 2'd0;

    // Randomized switches against the model
    for (int i = 0; i < 12; i++) begin
      sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) sel = model_mode;
      repeat ($urandom_range(0, 5)) step();
      do_switch(sel, ref_cfg(sel), int'($urandom_range(0, 25)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
